// File: rtl/uart_pkg.sv
// Shared definitions for the UART program loader: sync bytes, FSM state
// encodings and the baud divider helper.
package uart_pkg;

    localparam logic [7:0] SYNC0 = 8'h55;
    localparam logic [7:0] SYNC1 = 8'hAA;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_SYNC1,
        LD_LEN0,
        LD_LEN1,
        LD_DATA,
        LD_CHK,
        LD_DONE,
        LD_ERR
    } loader_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Clock cycles per bit, truncated toward zero.
    function automatic int unsigned bit_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer on rx, start-bit glitch rejection,
// mid-bit sampling of 8 data bits (LSB first) and a stop-bit check.
// Emits single-cycle byte_valid or frame_err pulses; nothing is buffered.
module uart_rx_byte #(
    parameter int unsigned CLK_HZ = 10000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    import uart_pkg::*;

    localparam int unsigned BIT_DIV  = bit_div(CLK_HZ, BAUD);
    localparam int unsigned HALF_DIV = BIT_DIV / 2;
    localparam int          CNT_W    = $clog2(BIT_DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Bring the asynchronous line into the clock domain; idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Bit-timing FSM: validate the start bit at half a bit, then sample each bit mid-cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                            state      <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: receives 55 AA LEN_LO LEN_HI followed by LEN
// little-endian 32-bit words and writes them to instruction memory from
// word address 0 upward, holding the CPU in reset while a download runs.
// Optional feature macro: UART_PROG_CHECKSUM_EN adds a trailing XOR
// checksum byte over all data bytes, checked before declaring success.
module uart_prog_loader #(
    parameter int unsigned CLK_HZ = 10000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [31:0]       prog_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import uart_pkg::*;

    // Largest image that fits the memory, in words.
    localparam logic [16:0] MAX_LEN = 17'(64'd1 << ADDR_W);

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_err;
    loader_state_t     state;
    logic [7:0]        len_lo;
    logic [15:0]       len_full;
    logic [ADDR_W-1:0] last_addr;
    logic [1:0]        byte_idx;
`ifdef UART_PROG_CHECKSUM_EN
    logic [7:0]        running_xor;
`endif

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign len_full = {byte_data, len_lo};

    // Loader FSM with word assembly and address counter; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LD_IDLE;
            len_lo      <= '0;
            last_addr   <= '0;
            byte_idx    <= '0;
            prog_we     <= 1'b0;
            prog_addr   <= '0;
            prog_wdata  <= '0;
            cpu_hold    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef UART_PROG_CHECKSUM_EN
            running_xor <= '0;
`endif
        end else begin
            prog_we <= 1'b0;
            if (frame_err && state != LD_IDLE && state != LD_DONE && state != LD_ERR) begin
                state    <= LD_ERR;
                err      <= 1'b1;
                busy     <= 1'b0;
                cpu_hold <= 1'b1;
            end else begin
                case (state)
                    LD_IDLE, LD_DONE, LD_ERR: begin
                        if (byte_valid && byte_data == SYNC0) begin
                            state    <= LD_SYNC1;
                            cpu_hold <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            err      <= 1'b0;
                        end
                    end
                    LD_SYNC1: begin
                        if (byte_valid) begin
                            if (byte_data == SYNC1) begin
                                state <= LD_LEN0;
                            end else begin
                                state <= LD_ERR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    LD_LEN0: begin
                        if (byte_valid) begin
                            len_lo <= byte_data;
                            state  <= LD_LEN1;
                        end
                    end
                    LD_LEN1: begin
                        if (byte_valid) begin
                            prog_addr   <= '0;
                            byte_idx    <= '0;
                            last_addr   <= ADDR_W'(len_full - 16'd1);
`ifdef UART_PROG_CHECKSUM_EN
                            running_xor <= '0;
`endif
                            if (len_full == 16'd0) begin
                                state    <= LD_DONE;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                cpu_hold <= 1'b0;
                            end else if ({1'b0, len_full} > MAX_LEN) begin
                                state <= LD_ERR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= LD_DATA;
                            end
                        end
                    end
                    LD_DATA: begin
                        if (prog_we) begin
                            // The final word leaves the address on itself so it never wraps.
                            if (prog_addr == last_addr) begin
`ifdef UART_PROG_CHECKSUM_EN
                                state <= LD_CHK;
`else
                                state    <= LD_DONE;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                cpu_hold <= 1'b0;
`endif
                            end else begin
                                prog_addr <= prog_addr + 1'b1;
                            end
                        end else if (byte_valid) begin
                            prog_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
                            byte_idx <= byte_idx + 2'd1;
`ifdef UART_PROG_CHECKSUM_EN
                            running_xor <= running_xor ^ byte_data;
`endif
                            if (byte_idx == 2'd3) begin
                                prog_we <= 1'b1;
                            end
                        end
                    end
`ifdef UART_PROG_CHECKSUM_EN
                    LD_CHK: begin
                        if (byte_valid) begin
                            busy <= 1'b0;
                            if (byte_data == running_xor) begin
                                state    <= LD_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state <= LD_ERR;
                                err   <= 1'b1;
                            end
                        end
                    end
`endif
                    default: state <= LD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Testbench for uart_prog_loader. Drives serial frames on rx at a fast bit
// rate (16 clocks per bit) and compares write strobes and status flags
// against a protocol-level reference of the download format.
module tb_uart_prog_loader;

    localparam int unsigned CLK_HZ = 10000000;
    localparam int unsigned BAUD   = 625000;
    localparam int          BD     = CLK_HZ / BAUD;
    localparam int          ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    uart_prog_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [7:0]        stream[$];

    // Reference state of the download protocol.
    int         m_phase;
    int         m_len;
    logic [7:0] m_xor;
    logic [7:0] m_payload[$];
    bit         exp_done, exp_err, exp_hold;

    // Log every write strobe seen by instruction memory.
    always @(negedge clk) begin
        if (prog_we) begin
            got_addr.push_back(prog_addr);
            got_data.push_back(prog_wdata);
        end
    end

    function automatic void model_reset();
        m_phase  = 0;
        m_len    = 0;
        m_xor    = '0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_hold = 1'b0;
        m_payload.delete();
    endfunction

    function automatic void model_ok();
        m_phase  = 0;
        exp_done = 1'b1;
        exp_hold = 1'b0;
    endfunction

    function automatic void model_fail();
        m_phase  = 0;
        exp_err  = 1'b1;
        exp_hold = 1'b1;
    endfunction

    function automatic bit exp_busy();
        return m_phase != 0;
    endfunction

    // Apply one received byte (or a framing error) to the protocol reference.
    function automatic void model_byte(input logic [7:0] b, input bit bad);
        int n;
        if (bad) begin
            if (m_phase != 0) model_fail();
            return;
        end
        case (m_phase)
            0: if (b == 8'h55) begin
                   m_phase  = 1;
                   exp_hold = 1'b1;
                   exp_done = 1'b0;
                   exp_err  = 1'b0;
               end
            1: if (b == 8'hAA) m_phase = 2; else model_fail();
            2: begin m_len = int'(b); m_phase = 3; end
            3: begin
                   m_len = m_len + 256 * int'(b);
                   m_xor = '0;
                   m_payload.delete();
                   if (m_len == 0) model_ok();
                   else if (m_len > (1 << ADDR_W)) model_fail();
                   else m_phase = 4;
               end
            4: begin
                   m_payload.push_back(b);
                   m_xor = m_xor ^ b;
                   n = m_payload.size();
                   if (n % 4 == 0) begin
                       exp_addr.push_back(ADDR_W'(n / 4 - 1));
                       exp_data.push_back({m_payload[n-1], m_payload[n-2], m_payload[n-3], m_payload[n-4]});
                   end
                   if (n == 4 * m_len) begin
`ifdef UART_PROG_CHECKSUM_EN
                       m_phase = 5;
`else
                       model_ok();
`endif
                   end
               end
            5: if (b == m_xor) model_ok(); else model_fail();
            default: ;
        endcase
    endfunction

    // Serialize one 8N1 frame on rx; bad_stop drives the stop bit low.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) @(negedge clk);
        end
        rx = !bad_stop;
        repeat (BD) @(negedge clk);
        rx = 1'b1;
        repeat (bad_stop ? BD : 2) @(negedge clk);
        model_byte(b, bad_stop);
    endtask

    task automatic send_range(input int first, input int last, input int bad_idx);
        for (int i = first; i <= last; i++) applyStimulus(stream[i], i == bad_idx);
        repeat (4) @(negedge clk);
    endtask

    // Build a complete image (header, words, optional checksum) into stream.
    task automatic make_image(input logic [31:0] words[$]);
        logic [15:0] nw;
        logic [7:0]  x;
        nw = 16'(words.size());
        x  = '0;
        stream.delete();
        stream.push_back(8'h55);
        stream.push_back(8'hAA);
        stream.push_back(nw[7:0]);
        stream.push_back(nw[15:8]);
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                stream.push_back(words[i][8*k +: 8]);
                x = x ^ words[i][8*k +: 8];
            end
        end
`ifdef UART_PROG_CHECKSUM_EN
        stream.push_back(x);
`endif
    endtask

    task automatic clear_logs();
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_logs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check_cnt++;
        if ({prog_we, prog_addr, prog_wdata, cpu_hold, busy, done, err} !== '0)
            $display("[TB] FAIL reset.hold got we=%0b addr=%0d data=%h hold=%0b busy=%0b done=%0b err=%0b want all 0",
                     prog_we, prog_addr, prog_wdata, cpu_hold, busy, done, err);
        else pass_cnt++;
        rst = 1'b0;
        model_reset();
        clear_logs();
        repeat (5) @(negedge clk);
        check_cnt++;
        if ({prog_we, prog_addr, prog_wdata, cpu_hold, busy, done, err} !== '0)
            $display("[TB] FAIL reset.release got hold=%0b busy=%0b done=%0b err=%0b want all 0", cpu_hold, busy, done, err);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [31:0] w[$];
        do_reset();
        w = '{32'h00000013, 32'h00000008};
        make_image(w);
        send_range(0, 1, -1);
        check_cnt++;
        if ({cpu_hold, busy} !== 2'b11) $display("[TB] FAIL basic.mid got hold=%0b busy=%0b want 1 1", cpu_hold, busy);
        else pass_cnt++;
        send_range(2, stream.size() - 1, -1);
        check_cnt++;
        if (got_addr.size() !== exp_addr.size()) $display("[TB] FAIL basic.count got %0d want %0d", got_addr.size(), exp_addr.size());
        else pass_cnt++;
        foreach (exp_addr[i]) if (i < got_addr.size()) begin
            check_cnt++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                $display("[TB] FAIL basic.write%0d got %0d:%h want %0d:%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if ({done, err, cpu_hold, busy} !== {exp_done, exp_err, exp_hold, exp_busy()})
            $display("[TB] FAIL basic.status got d=%0b e=%0b h=%0b b=%0b want %0b %0b %0b %0b",
                     done, err, cpu_hold, busy, exp_done, exp_err, exp_hold, exp_busy());
        else pass_cnt++;
    endtask

    task automatic test_lengths();
        do_reset();
        stream = '{8'h55, 8'hAA, 8'h00, 8'h00};
        send_range(0, 3, -1);
        check_cnt++;
        if (got_addr.size() !== 0 || {done, err, cpu_hold} !== {exp_done, exp_err, exp_hold})
            $display("[TB] FAIL len0 got writes=%0d d=%0b e=%0b h=%0b want 0 %0b %0b %0b",
                     got_addr.size(), done, err, cpu_hold, exp_done, exp_err, exp_hold);
        else pass_cnt++;
        stream = '{8'h55, 8'hAA, 8'h01, 8'h08};
        send_range(0, 3, -1);
        repeat (20) @(negedge clk);
        check_cnt++;
        if (got_addr.size() !== 0 || {done, err, cpu_hold, busy} !== {exp_done, exp_err, exp_hold, exp_busy()})
            $display("[TB] FAIL oversize got writes=%0d d=%0b e=%0b h=%0b b=%0b want 0 %0b %0b %0b %0b",
                     got_addr.size(), done, err, cpu_hold, busy, exp_done, exp_err, exp_hold, exp_busy());
        else pass_cnt++;
    endtask

    task automatic test_frame_err();
        logic [31:0] w[$];
        do_reset();
        w = '{32'hDEADBEEF, 32'h01020304};
        make_image(w);
        send_range(0, 5, 5);
        check_cnt++;
        if (got_addr.size() !== 0 || {done, err, cpu_hold, busy} !== {exp_done, exp_err, exp_hold, exp_busy()})
            $display("[TB] FAIL framing got writes=%0d d=%0b e=%0b h=%0b b=%0b want 0 %0b %0b %0b %0b",
                     got_addr.size(), done, err, cpu_hold, busy, exp_done, exp_err, exp_hold, exp_busy());
        else pass_cnt++;
        w = '{32'hCAFEF00D};
        make_image(w);
        send_range(0, stream.size() - 1, -1);
        check_cnt++;
        if (got_addr.size() !== exp_addr.size()) $display("[TB] FAIL recover.count got %0d want %0d", got_addr.size(), exp_addr.size());
        else pass_cnt++;
        foreach (exp_addr[i]) if (i < got_addr.size()) begin
            check_cnt++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                $display("[TB] FAIL recover.write%0d got %0d:%h want %0d:%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if ({done, err, cpu_hold} !== {exp_done, exp_err, exp_hold})
            $display("[TB] FAIL recover.status got d=%0b e=%0b h=%0b want %0b %0b %0b", done, err, cpu_hold, exp_done, exp_err, exp_hold);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic [31:0] w[$];
        do_reset();
        rx = 1'b0;
        repeat (BD / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BD) @(negedge clk);
        applyStimulus(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check_cnt++;
        if ({cpu_hold, busy, done, err} !== 4'b0000)
            $display("[TB] FAIL glitch.idle got h=%0b b=%0b d=%0b e=%0b want 0 0 0 0", cpu_hold, busy, done, err);
        else pass_cnt++;
        // A short glitch right before a real frame must not shift the bit timing.
        w = '{32'h89ABCDEF};
        make_image(w);
        rx = 1'b0;
        repeat (BD / 4) @(negedge clk);
        rx = 1'b1;
        repeat (BD / 4) @(negedge clk);
        send_range(0, stream.size() - 1, -1);
        check_cnt++;
        if (got_addr.size() !== 1 || got_data.size() !== 1 || got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0])
            $display("[TB] FAIL glitch.write got count=%0d want %0h at %0d", got_addr.size(), exp_data[0], exp_addr[0]);
        else pass_cnt++;
        check_cnt++;
        if ({done, err, cpu_hold} !== {exp_done, exp_err, exp_hold})
            $display("[TB] FAIL glitch.status got d=%0b e=%0b h=%0b want %0b %0b %0b", done, err, cpu_hold, exp_done, exp_err, exp_hold);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] w[$];
        do_reset();
        w = '{32'h11111111, 32'h22222222, 32'h33333333};
        make_image(w);
        send_range(0, 9, -1);
        check_cnt++;
        if (got_addr.size() !== 1 || busy !== 1'b1 || cpu_hold !== 1'b1)
            $display("[TB] FAIL rstmid.before got writes=%0d busy=%0b hold=%0b want 1 1 1", got_addr.size(), busy, cpu_hold);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        check_cnt++;
        if ({prog_we, prog_addr, prog_wdata, cpu_hold, busy, done, err} !== '0)
            $display("[TB] FAIL rstmid.outputs got addr=%0d data=%h hold=%0b busy=%0b want all 0", prog_addr, prog_wdata, cpu_hold, busy);
        else pass_cnt++;
        rst = 1'b0;
        model_reset();
        clear_logs();
        repeat (2) @(negedge clk);
        w = '{32'hA5A5A5A5, 32'h5A5A5A5A};
        make_image(w);
        send_range(0, stream.size() - 1, -1);
        check_cnt++;
        if (got_addr.size() !== exp_addr.size()) $display("[TB] FAIL rstmid.count got %0d want %0d", got_addr.size(), exp_addr.size());
        else pass_cnt++;
        foreach (exp_addr[i]) if (i < got_addr.size()) begin
            check_cnt++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                $display("[TB] FAIL rstmid.write%0d got %0d:%h want %0d:%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if ({done, err, cpu_hold} !== {exp_done, exp_err, exp_hold})
            $display("[TB] FAIL rstmid.status got d=%0b e=%0b h=%0b want %0b %0b %0b", done, err, cpu_hold, exp_done, exp_err, exp_hold);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        int bad_idx;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            clear_logs();
            w.delete();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) w.push_back($urandom);
            make_image(w);
            bad_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, stream.size() - 1)) : -1;
            send_range(0, stream.size() - 1, bad_idx);
            check_cnt++;
            if (got_addr.size() !== exp_addr.size())
                $display("[TB] FAIL random%0d.count got %0d want %0d", it, got_addr.size(), exp_addr.size());
            else pass_cnt++;
            foreach (exp_addr[i]) if (i < got_addr.size()) begin
                check_cnt++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                    $display("[TB] FAIL random%0d.write%0d got %0d:%h want %0d:%h", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                else pass_cnt++;
            end
            check_cnt++;
            if ({done, err, cpu_hold, busy} !== {exp_done, exp_err, exp_hold, exp_busy()})
                $display("[TB] FAIL random%0d.status got d=%0b e=%0b h=%0b b=%0b want %0b %0b %0b %0b",
                         it, done, err, cpu_hold, busy, exp_done, exp_err, exp_hold, exp_busy());
            else pass_cnt++;
        end
    endtask

`ifdef UART_PROG_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] w[$];
        do_reset();
        w = '{32'h11223344};
        make_image(w);
        send_range(0, stream.size() - 1, -1);
        check_cnt++;
        if ({done, err, cpu_hold} !== 3'b100 || stream[stream.size() - 1] !== 8'h44)
            $display("[TB] FAIL csum.good got d=%0b e=%0b h=%0b want 1 0 0", done, err, cpu_hold);
        else pass_cnt++;
        clear_logs();
        stream[stream.size() - 1] = 8'h45;
        send_range(0, stream.size() - 1, -1);
        check_cnt++;
        if ({done, err, cpu_hold} !== 3'b011 || got_addr.size() !== 1)
            $display("[TB] FAIL csum.bad got d=%0b e=%0b h=%0b writes=%0d want 0 1 1 1", done, err, cpu_hold, got_addr.size());
        else pass_cnt++;
        check_cnt++;
        if (got_data.size() < 1 || got_data[0] !== 32'h11223344 || got_addr[0] !== '0)
            $display("[TB] FAIL csum.write got count=%0d want 11223344 at 0", got_data.size());
        else pass_cnt++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        model_reset();
        $display("[TB] uart_prog_loader bench, %0d clocks per bit", BD);
        test_reset();
        test_basic();
        test_lengths();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
`ifdef UART_PROG_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
